icache_ctrl: RTL and testbench
==============================

ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have parameter NFRAMES, default 16, number of direct-mapped one-word frames (power of two, 2..256).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port imemREN  input  1  datapath instruction read request.
REQ-005 SHALL have port imemaddr  input  32  datapath instruction byte address.
REQ-006 SHALL have port ihit  output  1  requested word valid on imemload this cycle.
REQ-007 SHALL have port imemload  output  32  instruction word returned to datapath.
REQ-008 SHALL have port iREN  output  1  memory-side read request.
REQ-009 SHALL have port iaddr  output  32  memory-side word address.
REQ-010 SHALL have port iwait  input  1  memory busy; low means iload valid this cycle.
REQ-011 SHALL have port iload  input  32  memory-side read data.
REQ-012 SHALL have port miss_count  output  32  number of misses since reset.

Function
REQ-013 SHALL split imemaddr as byte offset [1:0] (ignored), index [log2(NFRAMES)+1:2], tag = remaining upper bits.
REQ-014 SHALL hold per frame: valid bit, tag, 32-bit data word.
REQ-015 SHALL implement FSM with states IDLE and FETCH.
REQ-016 IDLE: ihit = imemREN & valid[index] & (tag[index] == addr tag), combinational, zero-latency.
REQ-017 imemload SHALL equal data[index] when ihit=1 and 32'h0 when ihit=0.
REQ-018 IDLE, imemREN=1, no hit: latch {imemaddr[31:2],2'b00} into miss register, increment miss_count, go FETCH next cycle.
REQ-019 IDLE, imemREN=0: ihit=0, iREN=0, no state change, no counter change.
REQ-020 FETCH: iREN=1, iaddr = latched miss address; ihit=0 regardless of imemaddr.
REQ-021 FETCH, iwait=1: remain FETCH, hold iaddr stable.
REQ-022 FETCH, iwait=0: write iload, tag, valid=1 into frame indexed by latched address; return to IDLE next cycle.
REQ-023 Miss latency: ihit asserts exactly one cycle after the iwait=0 cycle, provided imemaddr still targets the filled word.
REQ-024 imemaddr change during FETCH (branch redirect) SHALL NOT abort the fill; IDLE re-evaluates the new address after fill completes.
REQ-025 Fill to an occupied frame SHALL overwrite it (no replacement choice).
REQ-026 In IDLE, iREN=0 and iaddr=32'h0.
REQ-027 miss_count SHALL saturate at 32'hFFFFFFFF.
REQ-028 Cache SHALL never write to memory; no dirty state.

Reset
REQ-029 RST=1 at a rising edge SHALL set state IDLE, all valid bits 0, miss register 0, miss_count 0; tag/data contents are don't-care.
REQ-030 Outputs during/after reset: ihit=0, imemload=0, iREN=0, iaddr=0, miss_count=0.
REQ-031 RST asserted in FETCH SHALL abort the fill; no frame written even if iwait=0 in that cycle; iREN=0 from the next cycle.

Verification
REQ-032 Cold miss: after reset, imemREN=1, imemaddr=0x00000040, memory iwait high 3 cycles then iload=0x2001000A -> iREN=1/iaddr=0x40 for 4 cycles, ihit=1 with imemload=0x2001000A on following cycle, miss_count=1.
REQ-033 Hit: repeat 0x00000040 and then 0x00000042 -> ihit=1 same cycle, imemload=0x2001000A, iREN=0, miss_count unchanged.
REQ-034 Conflict (NFRAMES=16): fill 0x40, then 0x80 (same index 0) -> 0x80 misses and evicts; re-access 0x40 misses again, miss_count=3.
REQ-035 Redirect: during FETCH of 0x100 change imemaddr to 0x200 -> iaddr stays 0x100 until iwait=0, then FETCH of 0x200 starts, miss_count=2.
REQ-036 Reset mid-fill: RST=1 in FETCH cycle with iwait=0, iload=0xDEADBEEF -> next cycle iREN=0, miss_count=0; re-access misses (valid cleared).
REQ-037 Idle: imemREN=0 for 10 cycles with any imemaddr -> ihit=0, iREN=0, miss_count unchanged.

Source files
------------

// File: rtl/icache_ctrl_if.sv
// Instruction cache bus bundle.
// Groups the datapath-side request/response signals, the memory-side read
// port and the miss counter.
//   master : datapath + instruction memory side (drives requests and fill data)
//   slave  : the cache controller
interface icache_ctrl_if;
    logic        imemREN;    // datapath read request
    logic [31:0] imemaddr;   // datapath byte address
    logic        ihit;       // word valid on imemload this cycle
    logic [31:0] imemload;   // instruction word to datapath
    logic        iREN;       // memory read request
    logic [31:0] iaddr;      // memory word address
    logic        iwait;      // memory busy, low = iload valid
    logic [31:0] iload;      // memory read data
    logic [31:0] miss_count; // misses since reset

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr, miss_count
    );

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr, miss_count
    );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped, one-word-per-frame, read-only instruction cache controller.
// Ports:
//   CLK  - single clock, rising edge
//   RST  - synchronous active-high reset
//   bus  - icache_ctrl_if.slave: datapath request/response, memory read
//          port and the saturating miss counter
// Address split: [1:0] byte offset (ignored), [IDXW+1:2] index, rest tag.
//
// state | meaning
// IDLE  | serve hits combinationally; a miss latches the address
// FETCH | read latched word from memory until iwait drops, then fill
module icache_ctrl #(
    parameter int NFRAMES = 16
) (
    input  logic         CLK,
    input  logic         RST,
    icache_ctrl_if.slave bus
);
    localparam int IDXW = $clog2(NFRAMES);
    localparam int TAGW = 32 - IDXW - 2;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t state, state_next;

    logic [NFRAMES-1:0] valid;
    logic [TAGW-1:0]    tag_mem  [NFRAMES];
    logic [31:0]        data_mem [NFRAMES];

    logic [31:0] miss_addr;
    logic [31:0] miss_count;

    logic [IDXW-1:0] req_idx;
    logic [TAGW-1:0] req_tag;
    logic [IDXW-1:0] fill_idx;
    logic [TAGW-1:0] fill_tag;

    logic        miss_en;
    logic        fill_en;
    logic        hit;
    logic [31:0] load;
    logic        ren;
    logic [31:0] raddr;

    assign req_idx  = bus.imemaddr[IDXW+1:2];
    assign req_tag  = bus.imemaddr[31:IDXW+2];
    assign fill_idx = miss_addr[IDXW+1:2];
    assign fill_tag = miss_addr[31:IDXW+2];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            valid      <= '0;
            miss_addr  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_next;
            if (miss_en) begin
                miss_addr <= {bus.imemaddr[31:2], 2'b00};
                if (miss_count != 32'hFFFF_FFFF)
                    miss_count <= miss_count + 32'd1;
            end
            if (fill_en)
                valid[fill_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset; valid bits guard them. A reset in FETCH
    // must still suppress the fill.
    always_ff @(posedge CLK) begin
        if (fill_en && !RST) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= bus.iload;
        end
    end

    always_comb begin
        state_next = state;
        miss_en    = 1'b0;
        fill_en    = 1'b0;
        hit        = 1'b0;
        load       = 32'h0;
        ren        = 1'b0;
        raddr      = 32'h0;
        case (state)
            IDLE: begin
                if (bus.imemREN) begin
                    if (valid[req_idx] && (tag_mem[req_idx] == req_tag)) begin
                        hit  = 1'b1;
                        load = data_mem[req_idx];
                    end else begin
                        miss_en    = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                // a redirect of imemaddr here is ignored; IDLE re-evaluates it
                ren   = 1'b1;
                raddr = miss_addr;
                if (!bus.iwait) begin
                    fill_en    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held.
    assign bus.ihit       = hit  & ~RST;
    assign bus.imemload   = RST ? 32'h0 : load;
    assign bus.iREN       = ren  & ~RST;
    assign bus.iaddr      = RST ? 32'h0 : raddr;
    assign bus.miss_count = RST ? 32'h0 : miss_count;
endmodule

// File: tb/tb_icache_ctrl.sv
module tb_icache_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    icache_ctrl_if bus ();

    icache_ctrl #(.NFRAMES(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        ren;
        logic [31:0] addr;
        logic        iwait;
        logic [31:0] iload;
        logic        e_hit;
        logic [31:0] e_load;
        logic        e_iren;
        logic [31:0] e_iaddr;
        logic [31:0] e_mc;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void v(logic rst, logic ren, logic [31:0] addr,
                              logic iwait, logic [31:0] iload,
                              logic e_hit, logic [31:0] e_load,
                              logic e_iren, logic [31:0] e_iaddr,
                              logic [31:0] e_mc);
        vec_t t;
        t.rst = rst; t.ren = ren; t.addr = addr; t.iwait = iwait;
        t.iload = iload; t.e_hit = e_hit; t.e_load = e_load;
        t.e_iren = e_iren; t.e_iaddr = e_iaddr; t.e_mc = e_mc;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_hit,
                           input logic [31:0] e_load, input logic e_iren,
                           input logic [31:0] e_iaddr, input logic [31:0] e_mc);
        chk({tag, ".ihit"},       {31'd0, bus.ihit}, {31'd0, e_hit});
        chk({tag, ".imemload"},   bus.imemload,      e_load);
        chk({tag, ".iREN"},       {31'd0, bus.iREN}, {31'd0, e_iren});
        chk({tag, ".iaddr"},      bus.iaddr,         e_iaddr);
        chk({tag, ".miss_count"}, bus.miss_count,    e_mc);
    endtask

    task automatic drive(input logic rst, input logic ren,
                         input logic [31:0] addr, input logic iwait,
                         input logic [31:0] iload);
        RST          = rst;
        bus.imemREN  = ren;
        bus.imemaddr = addr;
        bus.iwait    = iwait;
        bus.iload    = iload;
    endtask

    initial begin
        int budget;
        bus.imemREN = 1'b0; bus.imemaddr = '0; bus.iwait = 1'b1; bus.iload = '0;

        //  rst ren addr          iwait iload         hit load          iren iaddr         mc
        // reset
        v(1, 0, 32'h0000_0000, 1, 32'h0,         0, 32'h0,         0, 32'h0,         0);
        v(1, 1, 32'h0000_0040, 1, 32'h0,         0, 32'h0,         0, 32'h0,         0);
        // cold miss 0x40, iwait high 3 cycles
        v(0, 1, 32'h0000_0040, 1, 32'h0,         0, 32'h0,         0, 32'h0,         0);
        v(0, 1, 32'h0000_0040, 1, 32'h0,         0, 32'h0,         1, 32'h0000_0040, 1);
        v(0, 1, 32'h0000_0040, 1, 32'h0,         0, 32'h0,         1, 32'h0000_0040, 1);
        v(0, 1, 32'h0000_0040, 1, 32'h0,         0, 32'h0,         1, 32'h0000_0040, 1);
        v(0, 1, 32'h0000_0040, 0, 32'h2001_000A, 0, 32'h0,         1, 32'h0000_0040, 1);
        // hits, byte offset ignored
        v(0, 1, 32'h0000_0040, 1, 32'h0,         1, 32'h2001_000A, 0, 32'h0,         1);
        v(0, 1, 32'h0000_0042, 1, 32'h0,         1, 32'h2001_000A, 0, 32'h0,         1);
        v(0, 0, 32'h0000_0040, 1, 32'h0,         0, 32'h0,         0, 32'h0,         1);
        // conflict: 0x80 evicts 0x40 (both index 0)
        v(0, 1, 32'h0000_0080, 1, 32'h0,         0, 32'h0,         0, 32'h0,         1);
        v(0, 1, 32'h0000_0080, 0, 32'h1111_1111, 0, 32'h0,         1, 32'h0000_0080, 2);
        v(0, 1, 32'h0000_0080, 1, 32'h0,         1, 32'h1111_1111, 0, 32'h0,         2);
        v(0, 1, 32'h0000_0040, 1, 32'h0,         0, 32'h0,         0, 32'h0,         2);
        v(0, 1, 32'h0000_0040, 0, 32'h2001_000A, 0, 32'h0,         1, 32'h0000_0040, 3);
        v(0, 1, 32'h0000_0040, 1, 32'h0,         1, 32'h2001_000A, 0, 32'h0,         3);
        // reset, then redirect 0x100 -> 0x200 during fetch
        v(1, 0, 32'h0000_0000, 1, 32'h0,         0, 32'h0,         0, 32'h0,         0);
        v(0, 1, 32'h0000_0100, 1, 32'h0,         0, 32'h0,         0, 32'h0,         0);
        v(0, 1, 32'h0000_0200, 1, 32'h0,         0, 32'h0,         1, 32'h0000_0100, 1);
        v(0, 1, 32'h0000_0200, 1, 32'h0,         0, 32'h0,         1, 32'h0000_0100, 1);
        v(0, 1, 32'h0000_0200, 0, 32'h3333_3333, 0, 32'h0,         1, 32'h0000_0100, 1);
        v(0, 1, 32'h0000_0200, 1, 32'h0,         0, 32'h0,         0, 32'h0,         1);
        v(0, 1, 32'h0000_0200, 0, 32'h4444_4444, 0, 32'h0,         1, 32'h0000_0200, 2);
        v(0, 1, 32'h0000_0200, 1, 32'h0,         1, 32'h4444_4444, 0, 32'h0,         2);
        // reset during fetch with iwait low: fill must be dropped
        v(0, 1, 32'h0000_0040, 1, 32'h0,         0, 32'h0,         0, 32'h0,         2);
        v(1, 1, 32'h0000_0040, 0, 32'hDEAD_BEEF, 0, 32'h0,         0, 32'h0,         0);
        v(0, 1, 32'h0000_0040, 1, 32'h0,         0, 32'h0,         0, 32'h0,         0);
        v(0, 1, 32'h0000_0040, 1, 32'h0,         0, 32'h0,         1, 32'h0000_0040, 1);
        v(0, 1, 32'h0000_0040, 0, 32'h5555_5555, 0, 32'h0,         1, 32'h0000_0040, 1);
        v(0, 1, 32'h0000_0040, 1, 32'h0,         1, 32'h5555_5555, 0, 32'h0,         1);
        // neighbouring index does not disturb index 0
        v(0, 1, 32'h0000_0044, 1, 32'h0,         0, 32'h0,         0, 32'h0,         1);
        v(0, 1, 32'h0000_0044, 0, 32'h6666_6666, 0, 32'h0,         1, 32'h0000_0044, 2);
        v(0, 1, 32'h0000_0040, 1, 32'h0,         1, 32'h5555_5555, 0, 32'h0,         2);
        v(0, 1, 32'h0000_0047, 1, 32'h0,         1, 32'h6666_6666, 0, 32'h0,         2);

        foreach (vecs[i]) begin
            @(negedge CLK);
            drive(vecs[i].rst, vecs[i].ren, vecs[i].addr, vecs[i].iwait, vecs[i].iload);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_load,
                    vecs[i].e_iren, vecs[i].e_iaddr, vecs[i].e_mc);
        end

        // idle: 10 cycles with no request, arbitrary addresses
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            drive(0, 0, (k == 0) ? 32'h0000_0040 : $urandom, 1, $urandom);
            #1;
            chk_all($sformatf("idle%0d", k), 0, 32'h0, 0, 32'h0, 2);
        end

        // top index (15), memory responds after a bounded wait
        @(negedge CLK);
        drive(0, 1, 32'h0000_07FC, 1, 32'h0);
        #1;
        chk_all("top.miss", 0, 32'h0, 0, 32'h0, 2);
        budget = 0;
        do begin
            @(negedge CLK);
            budget++;
            #1;
        end while (!bus.iREN && budget < 10);
        chk("top.iREN_seen", {31'd0, bus.iREN}, 32'd1);
        chk("top.iaddr", bus.iaddr, 32'h0000_07FC);
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            #1;
            chk($sformatf("top.hold%0d", k), bus.iaddr, 32'h0000_07FC);
        end
        @(negedge CLK);
        drive(0, 1, 32'h0000_07FC, 0, 32'hCAFE_F00D);
        #1;
        chk_all("top.fill", 0, 32'h0, 1, 32'h0000_07FC, 3);
        @(negedge CLK);
        drive(0, 1, 32'h0000_07FC, 1, 32'h0);
        #1;
        chk_all("top.hit", 1, 32'hCAFE_F00D, 0, 32'h0, 3);
        // index 0 still holds its own word
        @(negedge CLK);
        drive(0, 1, 32'h0000_0040, 1, 32'h0);
        #1;
        chk_all("top.other", 1, 32'h5555_5555, 0, 32'h0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
